// File: rtl/seq_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module   : seq_encoder_8to3
// Purpose  : Sequential 8-to-3 priority encoder. A request vector d is
//            latched on accept and then drained one code per transfer.
//            Codes come out lowest set bit first (d[0] has top priority),
//            and {C,B,A} = index, with A as the LSB.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            en         - global enable; low freezes state and handshakes
//            req_valid  - d carries a request vector
//            d[7:0]     - request vector, bit i requests code i
//            req_ready  - vector can be accepted this cycle
//            A, B, C    - code bits 0 (LSB), 1 and 2 (MSB)
//            out_valid  - {C,B,A} holds a valid code
//            out_ready  - consumer takes the code this cycle
//            last       - current code is the final pending one
//            pending    - set bits not yet emitted (0..8)
// Revision : 1.0 - initial release
// ============================================================================
module seq_encoder_8to3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req_valid,
    input  logic [7:0] d,
    output logic       req_ready,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic [3:0] pending
);

    // One-hot encoding leaves 2'b00 and 2'b11 unreachable; both are
    // steered back to idle with the mask cleared.
    localparam logic [1:0] c_IDLE  = 2'b01;
    localparam logic [1:0] c_DRAIN = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_mask;
    logic [7:0] w_mask_nxt;
    logic [3:0] r_pending;
    logic [3:0] w_pending_nxt;

    logic       w_in_idle;
    logic       w_in_drain;
    logic       w_accept;
    logic       w_xfer;
    logic [3:0] w_d_count;
    logic [2:0] w_low_idx;
    logic [7:0] w_low_bit;

    assign w_in_idle  = (r_state == c_IDLE);
    assign w_in_drain = (r_state == c_DRAIN);

    // rst_n gates req_ready so nothing is advertised while reset is held,
    // even though the state register already reads idle.
    assign req_ready = rst_n & en & w_in_idle;
    assign out_valid = en & w_in_drain;
    assign w_accept  = req_ready & req_valid;
    assign w_xfer    = out_valid & out_ready;

    // Population count of the incoming vector, loaded into pending on accept.
    always_comb begin
        w_d_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_d_count = w_d_count + {3'b000, d[i]};
        end
    end

    // Index of the lowest set mask bit; scanning downward lets the lowest
    // index win. An empty mask yields code 0.
    always_comb begin
        w_low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit for clearing.
    assign w_low_bit = r_mask & (~r_mask + 8'd1);

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_pending_nxt = r_pending;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_mask_nxt    = d;
                    w_pending_nxt = w_d_count;
                    w_state_nxt   = (d != 8'd0) ? c_DRAIN : c_IDLE;
                end
            end
            c_DRAIN: begin
                if (w_xfer) begin
                    w_mask_nxt    = r_mask & ~w_low_bit;
                    w_pending_nxt = r_pending - 4'd1;
                    if (r_pending == 4'd1) begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = c_IDLE;
                w_mask_nxt    = 8'd0;
                w_pending_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_mask    <= 8'd0;
            r_pending <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Code and count derive only from registered state, so they hold
    // steady through stalls and carry no path from d or req_valid.
    assign {C, B, A} = w_low_idx;
    assign last      = out_valid & (r_pending == 4'd1);
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seq_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_encoder_8to3
// Purpose  : Self-checking bench for seq_encoder_8to3. A queue of pending
//            code indices models the block; directed scenarios are
//            followed by randomized traffic with occasional resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] d = 8'd0;
    logic       out_ready = 1'b0;
    logic       req_ready;
    logic       A, B, C;
    logic       out_valid;
    logic       last;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;
    int q[$];

    seq_encoder_8to3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .d         (d),
        .req_ready (req_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_check();
        chk("rst_req_ready", {7'd0, req_ready}, 8'd0);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_last",      {7'd0, last}, 8'd0);
        chk("rst_pending",   {4'd0, pending}, 8'd0);
        chk("rst_code",      {5'd0, C, B, A}, 8'd0);
    endtask

    // Check outputs against the queue model, advance the model by the
    // handshakes seen this cycle, then move one clock edge on.
    task automatic cyc();
        logic erv, eov;
        #2;
        erv = rst_n && en && (q.size() == 0);
        eov = rst_n && en && (q.size() != 0);
        chk("req_ready", {7'd0, req_ready}, {7'd0, erv});
        chk("out_valid", {7'd0, out_valid}, {7'd0, eov});
        chk("pending",   {4'd0, pending}, 8'(q.size()));
        chk("last",      {7'd0, last}, {7'd0, (eov && q.size() == 1)});
        if (eov) chk("code", {5'd0, C, B, A}, 8'(q[0]));
        if (eov && out_ready) void'(q.pop_front());
        if (erv && req_valid) begin
            for (int i = 0; i < 8; i++) begin
                if (d[i]) q.push_back(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        req_valid = 1'b1;
        d = v;
        cyc();
        req_valid = 1'b0;
        d = 8'($urandom);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        reset_check();
        q.delete();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held with en high: req_ready must still read 0.
        en = 1'b1;
        #12;
        reset_check();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();

        // Single-bit sweep.
        for (int i = 0; i < 8; i++) begin
            send(8'(1 << i));
            cyc();
            cyc();
        end

        // Multi-bit drain: codes 1,2,5,7.
        send(8'b1010_0110);
        repeat (5) cyc();

        // Backpressure on a full vector.
        send(8'hFF);
        for (int k = 0; k < 24; k++) begin
            out_ready = ((k % 3) == 0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();

        // Empty vector, then a blocked request during drain.
        send(8'h00);
        cyc();
        out_ready = 1'b0;
        send(8'h0F);
        req_valid = 1'b1;
        d = 8'hF0;
        repeat (2) cyc();
        req_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();

        // Enable freeze after the first code.
        send(8'h81);
        cyc();
        en = 1'b0;
        repeat (3) cyc();
        en = 1'b1;
        repeat (2) cyc();

        // Reset mid-drain, then a fresh single-bit vector.
        send(8'h3C);
        cyc();
        async_reset();
        send(8'h01);
        repeat (2) cyc();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            en        = ($urandom_range(0, 9) != 0);
            req_valid = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'(1 << $urandom_range(0, 7));
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) async_reset();
            else cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_encoder_8to3.md
SEQ_ENCODER_8TO3 -- requirements
Module: seq_encoder_8to3

Interface
REQ-001 SHALL have no parameters; widths are fixed at 8 request lines to 3 code bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 en  input  1  global enable; low SHALL freeze all state and suppress both handshakes.
REQ-005 req_valid  input  1  a request vector is offered on d.
REQ-006 d  input  8  request vector, d[0]..d[7]; bit i requests code i.
REQ-007 req_ready  output  1  block can accept a vector this cycle.
REQ-008 A  output  1  code bit 0 (LSB).
REQ-009 B  output  1  code bit 1.
REQ-010 C  output  1  code bit 2 (MSB).
REQ-011 out_valid  output  1  {C,B,A} holds a valid code.
REQ-012 out_ready  input  1  consumer accepts the code this cycle.
REQ-013 last  output  1  the current code is the final pending bit of its vector.
REQ-014 pending  output  4  number of set bits not yet emitted, range 0..8.

Function
REQ-015 SHALL implement the inverse of the team's 3-to-8 decoder: code index i SHALL drive {C,B,A} = i, with A as LSB.
REQ-016 SHALL use two states, IDLE and DRAIN.
REQ-017 In IDLE, req_ready SHALL be 1 when en=1 and 0 when en=0; out_valid SHALL be 0.
REQ-018 Accept SHALL occur when en & req_valid & req_ready; d SHALL then be latched into an internal 8-bit mask.
REQ-019 Accepting a nonzero d SHALL move the block to DRAIN on the next cycle; pending SHALL equal popcount(d).
REQ-020 Accepting d=8'h00 SHALL leave the block in IDLE with no output and pending=0.
REQ-021 In DRAIN, req_ready SHALL be 0; input vectors SHALL NOT be accepted or merged.
REQ-022 In DRAIN with en=1, out_valid SHALL be 1 and {C,B,A} SHALL be the index of the lowest set mask bit; d[0] has highest priority.
REQ-023 Outputs SHALL come from registers or from the registered mask only; no combinational path SHALL run from d or req_valid to the outputs.
REQ-024 Latency: the first code SHALL be valid on the cycle after accept, then one code per cycle while out_ready=1.
REQ-025 A transfer SHALL occur when out_valid & out_ready; the emitted mask bit SHALL then clear and pending SHALL decrement by 1.
REQ-026 With out_ready=0, {C,B,A}, last, and pending SHALL hold stable while out_valid stays 1.
REQ-027 last SHALL be 1 exactly when out_valid=1 and pending=1.
REQ-028 Transferring the last code SHALL return the block to IDLE, with req_ready=1 on the next cycle if en=1.
REQ-029 With en=0 in DRAIN, out_valid SHALL be 0, no transfer SHALL occur, and mask and pending SHALL hold; draining SHALL resume when en returns.
REQ-030 Unreachable encodings SHALL recover to IDLE with the mask cleared.

Reset
REQ-031 When rst_n=0: state SHALL be IDLE, mask=0, pending=0, A=B=C=0, out_valid=0, last=0, and req_ready=0.
REQ-032 After rst_n rises, req_ready SHALL follow REQ-017 from the first clock edge.
REQ-033 Reset asserted mid-DRAIN SHALL discard all undelivered codes immediately (asynchronously), with no partial output after release.

Verification
REQ-034 Single-bit sweep: for i=0..7 send d=1<<i with out_ready=1 -> one code with {C,B,A}=i, last=1, pending 1->0, back in IDLE.
REQ-035 Multi-bit drain: d=8'b1010_0110 with out_ready=1 -> codes 1,2,5,7 on consecutive cycles, pending 4,3,2,1, last only on code 7.
REQ-036 Backpressure: d=8'hFF with out_ready toggling 1,0,0,1,... -> codes 0..7 in order, outputs stable in stall cycles, req_ready=0 until the final transfer.
REQ-037 Empty vector and blocked input: d=8'h00 accepted -> out_valid stays 0; a new req_valid during DRAIN -> not accepted and does not alter the mask.
REQ-038 Enable freeze: d=8'h81, en=0 after the first code -> out_valid=0, pending=1 held; en=1 -> code 7 with last=1.
REQ-039 Reset mid-operation: rst_n low during DRAIN of d=8'h3C -> all outputs take reset values at once; after release, d=8'h01 -> code 0 only.
